// File: rtl/expr_tx.sv
// expr_tx: streams "[(]a op1 b[)] op2 c TERM" as decimal ASCII over a valid/ready port.
module expr_tx #(
  parameter logic [7:0] TERM = 8'h3D
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic       op1,
  input  logic       op2,
  input  logic       paren,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);
  typedef enum logic [3:0] {S_IDLE, S_LPAR, S_OPA, S_OP1, S_OPB, S_RPAR, S_OP2, S_OPC, S_TERM} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [7:0] ra, rb, rc, cur, digit;
  logic r1, r2, rp, last;

  // digit index 0/1/2 = hundreds/tens/ones; start at the first nonzero digit
  function automatic logic [1:0] first(input logic [7:0] v);
    return v >= 8'd100 ? 2'd0 : v >= 8'd10 ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [7:0] sym(input logic m);
    return m ? 8'h2A : 8'h2B;
  endfunction

  always_comb begin
    cur = state == S_OPA ? ra : state == S_OPB ? rb : rc;
    digit = idx == 2'd0 ? cur / 8'd100 : idx == 2'd1 ? (cur / 8'd10) % 8'd10 : cur % 8'd10;
    last = idx == 2'd2;
    busy = state != S_IDLE;
    out_valid = busy;
    out = state == S_LPAR ? 8'h28 :
          state == S_RPAR ? 8'h29 :
          state == S_OP1  ? sym(r1) :
          state == S_OP2  ? sym(r2) :
          state == S_TERM ? TERM :
          (state == S_OPA || state == S_OPB || state == S_OPC) ? 8'h30 + digit : 8'h00;
  end

  always_comb begin
    state_n = state;
    idx_n = idx;
    if (state == S_IDLE) begin
      if (start) begin
        state_n = paren ? S_LPAR : S_OPA;
        idx_n = first(a);
      end
    end else if (out_ready) begin
      case (state)
        S_LPAR: state_n = S_OPA;
        S_OPA:  if (last) state_n = S_OP1; else idx_n = idx + 2'd1;
        S_OP1:  begin state_n = S_OPB; idx_n = first(rb); end
        S_OPB:  if (last) state_n = rp ? S_RPAR : S_OP2; else idx_n = idx + 2'd1;
        S_RPAR: state_n = S_OP2;
        S_OP2:  begin state_n = S_OPC; idx_n = first(rc); end
        S_OPC:  if (last) state_n = S_TERM; else idx_n = idx + 2'd1;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      idx <= 2'd0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      done <= state == S_TERM && out_ready;
    end
    if (!clr && state == S_IDLE && start) begin
      ra <= a;
      rb <= b;
      rc <= c;
      r1 <= op1;
      r2 <= op2;
      rp <= paren;
    end
  end
endmodule

// File: tb/tb_expr_tx.sv
// tb_expr_tx: directed frames with a queue scoreboard checked by an independent output monitor.
module tb_expr_tx;
  logic clk = 0, clr = 1, start = 0, op1 = 0, op2 = 0, paren = 0, out_ready = 1;
  logic [7:0] a = 0, b = 0, c = 0;
  logic [7:0] out;
  logic out_valid, busy, done;
  logic [7:0] q[$];
  int errs = 0, checks = 0;
  int n;

  expr_tx dut (
    .clk(clk), .clr(clr), .start(start), .a(a), .b(b), .c(c),
    .op1(op1), .op2(op2), .paren(paren), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (out_valid === 1'b1 && out_ready && !clr) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL extra_char: got %0h expected none", out);
      end else chk("char", out, q.pop_front());
    end

  function automatic string frame(int va, int vb, int vc, bit o1, bit o2, bit p);
    string lp, rp, s1, s2;
    lp = p ? "(" : "";
    rp = p ? ")" : "";
    s1 = o1 ? "*" : "+";
    s2 = o2 ? "*" : "+";
    return $sformatf("%s%0d%s%0d%s%s%0d=", lp, va, s1, vb, rp, s2, vc);
  endfunction

  task automatic go(int va, int vb, int vc, bit o1, bit o2, bit p, int keep = 99);
    string s;
    s = frame(va, vb, vc, o1, o2, p);
    for (int i = 0; i < s.len() && i < keep; i++) q.push_back(s[i]);
    a = va[7:0]; b = vb[7:0]; c = vc[7:0]; op1 = o1; op2 = o2; paren = p;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < 200);
    chk("done_seen", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 clr = 0;
    go(12, 3, 45, 0, 1, 1);
    wait_done(n);
    chk("t1_done_cycle", n, 11);
    chk("t1_busy_after", busy, 0);
    chk("t1_valid_after", out_valid, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    go(0, 255, 7, 1, 0, 0);
    wait_done(n);
    chk("t2_done_cycle", n, 9);
    go(12, 3, 45, 0, 1, 1);
    @(posedge clk);
    #1 out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out", out, 8'h31);
      chk("stall_valid", out_valid, 1);
    end
    @(posedge clk);
    #1 out_ready = 1;
    wait_done(n);
    go(5, 6, 7, 1, 1, 0);
    @(posedge clk);
    #1 start = 1; a = 99; b = 98; c = 97; op1 = 0; paren = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done(n);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_queued_frame", busy, 0);
    end
    go(12, 3, 45, 0, 1, 1, 4);
    repeat (4) @(posedge clk);
    #1 clr = 1;
    @(posedge clk);
    #1 clr = 0;
    @(negedge clk);
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_out", out, 0);
    chk("clr_done", done, 0);
    chk("clr_queue", q.size(), 0);
    @(negedge clk);
    chk("clr_no_resume", busy, 0);
    go(12, 3, 45, 0, 1, 1);
    wait_done(n);
    go(100, 10, 9, 0, 0, 0);
    wait_done(n);
    go(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_first", out, 8'h30);
    wait_done(n);
    chk("min_done_cycle", n, 6);
    go(255, 255, 255, 1, 1, 1);
    wait_done(n);
    chk("max_done_cycle", n, 15);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
